ad_seq_ctrl: RTL and testbench
==============================

Name: ad_seq_ctrl

Overview:
Sequencer for the serial ADC channel interface (cs_n/sclk/sdata, 16-bit frame: 4 leading zeros followed by 12 data bits, MSB first). It issues conversion frames either periodically or on a single software trigger, generates cs_n and sclk, and deserialises sdata. Each 12-bit result is presented on a valid/ready stream toward the downstream datapath (UART report path). It sits between the ch1 ADC pins and the sample consumer.

Parameters:
DIV, 4, sclk half-period in clk_sys cycles (>=2)
NBITS, 16, sclk rising edges per frame
DBITS, 12, result width; last DBITS sampled bits are kept
TSU, 2, cycles cs_n is low before the first sclk falling edge
TQUIET, 4, cycles cs_n is high after a frame before a new frame may start

Ports:
clk_sys  in  1  system clock, single clock domain
rst_n  in  1  asynchronous active-low reset
cfg_en  in  1  periodic sampling enable
cfg_period  in  16  start-to-start period in clk_sys cycles; 0 treated as 1
trig_single  in  1  one-cycle pulse, starts one frame when idle
ad_cs_n  out  1  ADC chip select, active low
ad_sclk  out  1  ADC serial clock, idles high
ad_sdata  in  1  ADC serial data
smp_data  out  DBITS  latest result
smp_vld  out  1  result valid
smp_rdy  in  1  consumer ready
smp_cnt  out  16  completed-frame counter, wraps FFFF->0000
busy  out  1  frame in progress (SETUP/SHIFT/QUIET)
overrun  out  1  sticky: unconsumed result overwritten
ovr_clr  in  1  clears overrun

Behaviour:
- Reset (async, any state): ad_cs_n=1, ad_sclk=1, smp_data=0, smp_vld=0, smp_cnt=0, busy=0, overrun=0, period timer=0, FSM=IDLE.
- Start sources: period timer terminal count (cfg_en=1) OR trig_single. A start is accepted only in IDLE; a start arriving while busy is dropped (not queued).
- Period timer: counts 0..cfg_period-1 while cfg_en=1, start pulse at terminal, then reloads 0. cfg_en=0 holds timer at 0; an in-flight frame completes normally.
- FSM:
  - IDLE: cs_n=1, sclk=1. On accepted start -> SETUP next cycle.
  - SETUP: cs_n=0, sclk=1, TSU cycles -> SHIFT.
  - SHIFT: 2*DIV*NBITS cycles. sclk=0 on SHIFT cycle 0 and toggles every DIV cycles, ending high. On each clk_sys edge where sclk goes 0->1, ad_sdata is shifted into the shift register LSB (MSB first). After the last cycle -> QUIET.
  - QUIET: cs_n=1, sclk=1, TQUIET cycles -> IDLE. On the first QUIET cycle: smp_data <= shift[DBITS-1:0], smp_vld=1, smp_cnt++.
- busy=1 in SETUP, SHIFT and QUIET. cs_n low duration = TSU + 2*DIV*NBITS (130 cycles at defaults). Minimum useful period FRAME = TSU+2*DIV*NBITS+TQUIET+1 = 135 at defaults.
- Handshake: smp_vld stays high until a cycle with smp_vld&smp_rdy, which clears it. smp_data stays stable while smp_vld=1 unless a new capture occurs.
- New capture while smp_vld=1 and no handshake in that cycle: data overwritten, smp_vld stays 1, overrun<=1.
- New capture in the same cycle as a handshake: no overrun, smp_vld stays 1 with new data.
- ovr_clr clears overrun; if a new overrun event occurs in the same cycle, overrun stays 1.
- Leading (NBITS-DBITS) bits are discarded without checking.

Test Plan:
1. cfg_en=0, one trig_single pulse, ADC model sends 16'h0ABC -> cs_n low 130 cycles, 16 sclk rising edges, then smp_data=12'hABC, smp_vld=1 on cs_n rise cycle, smp_cnt=1, busy low after QUIET.
2. cfg_en=1, cfg_period=200, smp_rdy=1, model counts 1,2,3 -> cs_n falling edges exactly 200 cycles apart, smp_data 1,2,3, overrun=0.
3. cfg_period=100 -> every start landing in busy dropped; frames exactly 200 cycles apart, no frame shortened.
4. smp_rdy=0 across two frames (0x111, 0x222) -> overrun=1, smp_data=12'h222. ovr_clr pulse -> overrun=0. Repeat with smp_rdy asserted in the capture cycle -> overrun remains 0.
5. Assert rst_n=0 mid-SHIFT -> ad_cs_n=1 and ad_sclk=1 immediately (before the next clk_sys edge), smp_vld=0, smp_cnt=0. After release, trig_single yields a correct full frame.
6. Preload via 65535 frames (or force) -> smp_cnt goes FFFF->0000 on the next capture; trig_single while busy is ignored (count increments by 1 only).

Source files
------------

// File: rtl/ad_seq_ctrl.sv
// Serial ADC frame sequencer: drives cs_n/sclk, deserialises sdata and hands
// each DBITS-wide result to the consumer over a valid/ready stream.
module ad_seq_ctrl #(
  parameter int DIV    = 4,
  parameter int NBITS  = 16,
  parameter int DBITS  = 12,
  parameter int TSU    = 2,
  parameter int TQUIET = 4
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             cfg_en,
  input  logic [15:0]      cfg_period,
  input  logic             trig_single,
  output logic             ad_cs_n,
  output logic             ad_sclk,
  input  logic             ad_sdata,
  output logic [DBITS-1:0] smp_data,
  output logic             smp_vld,
  input  logic             smp_rdy,
  output logic [15:0]      smp_cnt,
  output logic             busy,
  output logic             overrun,
  input  logic             ovr_clr
);

  localparam int SHIFT_LEN = 2 * DIV * NBITS;
  localparam int CW        = $clog2(SHIFT_LEN + TSU + TQUIET + 1);
  localparam int DW        = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_QUIET} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    div_q, div_d;
  logic [DBITS-1:0] shift_q, shift_d;
  logic [15:0]      tmr_q, tmr_d;
  logic [15:0]      per_m1;
  logic             cs_n_q, cs_n_d;
  logic             sclk_q, sclk_d;
  logic             busy_q, busy_d;
  logic [DBITS-1:0] smp_data_q, smp_data_d;
  logic             smp_vld_q, smp_vld_d;
  logic [15:0]      smp_cnt_q, smp_cnt_d;
  logic             ovr_q, ovr_d;
  logic             tick, start, capture, sclk_rise;

  // Period timer: a period of 0 behaves as 1 (start request every cycle).
  always_comb begin
    per_m1 = (cfg_period == 16'd0) ? 16'd0 : cfg_period - 16'd1;
    tick   = cfg_en && (tmr_q >= per_m1);
    tmr_d  = (!cfg_en || tick) ? 16'd0 : tmr_q + 16'd1;
    start  = tick || trig_single;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_SETUP;
      end
      S_SETUP: if (cnt_q == CW'(TSU - 1)) begin
        state_d = S_SHIFT;
        cnt_d   = '0;
      end
      S_SHIFT: if (cnt_q == CW'(SHIFT_LEN - 1)) begin
        state_d = S_QUIET;
        cnt_d   = '0;
      end
      S_QUIET: if (cnt_q == CW'(TQUIET - 1)) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Pin outputs are registered from the next state so they never glitch.
  always_comb begin
    cs_n_d = 1'b1;
    sclk_d = 1'b1;
    div_d  = div_q;
    if (state_d == S_SETUP) begin
      cs_n_d = 1'b0;
    end else if (state_d == S_SHIFT) begin
      cs_n_d = 1'b0;
      if (state_q != S_SHIFT) begin
        sclk_d = 1'b0;
        div_d  = '0;
      end else if (div_q == DW'(DIV - 1)) begin
        sclk_d = ~sclk_q;
        div_d  = '0;
      end else begin
        sclk_d = sclk_q;
        div_d  = div_q + DW'(1);
      end
    end
    busy_d = (state_d != S_IDLE);
  end

  // Only the last DBITS bits survive the shift; leading bits fall off the top.
  always_comb begin
    sclk_rise  = (state_q == S_SHIFT) && !sclk_q && sclk_d;
    shift_d    = sclk_rise ? {shift_q[DBITS-2:0], ad_sdata} : shift_q;
    capture    = (state_q == S_SHIFT) && (state_d == S_QUIET);
    smp_data_d = capture ? shift_q : smp_data_q;
    smp_vld_d  = capture || (smp_vld_q && !smp_rdy);
    smp_cnt_d  = smp_cnt_q + {15'd0, capture};
    ovr_d      = (capture && smp_vld_q && !smp_rdy) || (ovr_q && !ovr_clr);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      tmr_q      <= '0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b1;
      busy_q     <= 1'b0;
      smp_data_q <= '0;
      smp_vld_q  <= 1'b0;
      smp_cnt_q  <= '0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      shift_q    <= shift_d;
      tmr_q      <= tmr_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      busy_q     <= busy_d;
      smp_data_q <= smp_data_d;
      smp_vld_q  <= smp_vld_d;
      smp_cnt_q  <= smp_cnt_d;
      ovr_q      <= ovr_d;
    end
  end

  assign ad_cs_n  = cs_n_q;
  assign ad_sclk  = sclk_q;
  assign busy     = busy_q;
  assign smp_data = smp_data_q;
  assign smp_vld  = smp_vld_q;
  assign smp_cnt  = smp_cnt_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_ad_seq_ctrl.sv
// Bench for ad_seq_ctrl: serial ADC model, pin-level frame monitor and
// per-scenario checks against expectations derived from the frame rules.
`timescale 1ns/1ps
module tb_ad_seq_ctrl;
  localparam int FRAME_LOW = 130;  // TSU + 2*DIV*NBITS
  localparam int FRAME     = 135;  // start-to-next-possible-start

  logic        clk_sys = 1'b0, rst_n = 1'b1, cfg_en = 1'b0, trig_single = 1'b0;
  logic        ad_sdata = 1'b0, smp_rdy = 1'b0, ovr_clr = 1'b0;
  logic [15:0] cfg_period = 16'd200;
  logic        ad_cs_n, ad_sclk, smp_vld, busy, overrun;
  logic [11:0] smp_data;
  logic [15:0] smp_cnt;
  int          total = 0, bad = 0, exp_cnt = 0;

  always #5 clk_sys = ~clk_sys;

  ad_seq_ctrl dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_period(cfg_period),
    .trig_single(trig_single), .ad_cs_n(ad_cs_n), .ad_sclk(ad_sclk),
    .ad_sdata(ad_sdata), .smp_data(smp_data), .smp_vld(smp_vld),
    .smp_rdy(smp_rdy), .smp_cnt(smp_cnt), .busy(busy), .overrun(overrun),
    .ovr_clr(ovr_clr)
  );

  // ADC: loads next queued word on cs_n fall, shifts MSB first on sclk fall.
  logic [15:0] words[$];
  int          widx = 0, bidx = -1;
  logic [15:0] cur = 16'h0F0F;
  always @(negedge ad_cs_n) begin
    if (widx < words.size()) begin cur = words[widx]; widx++; end
    else cur = 16'h0F0F;
    bidx = 15;
  end
  always @(negedge ad_sclk) if (!ad_cs_n && bidx >= 0) begin
    ad_sdata = cur[bidx];
    bidx--;
  end

  // Frame monitor: start times, cs_n low length, sclk rises, result at cs_n rise.
  int         cyc = 0, fall_t = 0, nrise = 0;
  logic       pcs = 1'b1, psck = 1'b1;
  int         fall_q[$], len_q[$], rise_q[$];
  logic [11:0] dat_q[$];
  logic       vat_q[$];
  always @(negedge clk_sys) begin
    cyc++;
    if (pcs && !ad_cs_n) begin fall_q.push_back(cyc); fall_t = cyc; nrise = 0; end
    if (!ad_cs_n && !psck && ad_sclk) nrise++;
    if (!pcs && ad_cs_n) begin
      len_q.push_back(cyc - fall_t); rise_q.push_back(nrise);
      dat_q.push_back(smp_data); vat_q.push_back(smp_vld);
    end
    pcs  = ad_cs_n;
    psck = ad_sclk;
  end

  task automatic pulse_trig();
    @(negedge clk_sys); trig_single = 1'b1;
    @(negedge clk_sys); trig_single = 1'b0;
  endtask

  task automatic wait_rec(input int target, output bit ok);
    int n = 0;
    while (len_q.size() < target && n < 2000) begin @(negedge clk_sys); n++; end
    ok = (len_q.size() >= target);
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy !== 1'b0 && n < 400) begin @(negedge clk_sys); n++; end
    ok = (busy === 1'b0);
    @(negedge clk_sys);
  endtask

  task automatic wait_fall(output bit ok);
    int n = 0;
    while (ad_cs_n !== 1'b0 && n < 300) begin @(negedge clk_sys); n++; end
    ok = (ad_cs_n === 1'b0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    total++;
    if ({ad_cs_n, ad_sclk, smp_vld, busy, overrun} !== 5'b11000 || smp_data !== 12'd0 || smp_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset cs_n=%b sclk=%b vld=%b busy=%b ovr=%b data=%h cnt=%h want 1 1 0 0 0 000 0000",
               ad_cs_n, ad_sclk, smp_vld, busy, overrun, smp_data, smp_cnt);
    end
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk_sys);
  endtask

  task automatic test_single();
    int lb; bit ok, ok2; logic [15:0] w;
    cfg_en = 1'b0; smp_rdy = 1'b0;
    lb = len_q.size();
    words.push_back(16'h0ABC);
    pulse_trig();
    total++;
    if (busy !== 1'b1 || ad_cs_n !== 1'b0) begin
      bad++; $display("FAIL single_start busy=%b cs_n=%b want 1 0", busy, ad_cs_n);
    end
    wait_rec(lb + 1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL single_timeout no frame seen"); return; end
    exp_cnt++;
    total++;
    if (len_q[lb] != FRAME_LOW || rise_q[lb] != 16) begin
      bad++; $display("FAIL single_shape low=%0d rises=%0d want %0d 16", len_q[lb], rise_q[lb], FRAME_LOW);
    end
    total++;
    if (dat_q[lb] !== 12'hABC || vat_q[lb] !== 1'b1 || smp_cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL single_result data=%h vld=%b cnt=%0d want abc 1 %0d", dat_q[lb], vat_q[lb], smp_cnt, exp_cnt);
    end
    repeat (20) @(negedge clk_sys);
    total++;
    if (busy !== 1'b0 || smp_vld !== 1'b1 || smp_data !== 12'hABC) begin
      bad++; $display("FAIL single_hold busy=%b vld=%b data=%h want 0 1 abc", busy, smp_vld, smp_data);
    end
    smp_rdy = 1'b1; @(negedge clk_sys); smp_rdy = 1'b0;
    total++;
    if (smp_vld !== 1'b0 || smp_data !== 12'hABC) begin
      bad++; $display("FAIL single_handshake vld=%b data=%h want 0 abc", smp_vld, smp_data);
    end
    for (int i = 0; i < 3; i++) begin
      w = 16'($urandom);
      words.push_back(w);
      lb = len_q.size();
      smp_rdy = 1'b1;
      pulse_trig();
      wait_rec(lb + 1, ok);
      wait_idle(ok2);
      total++;
      if (!ok || !ok2) begin bad++; $display("FAIL single_rand_timeout iter=%0d", i); end
      else begin
        exp_cnt++;
        if (dat_q[lb] !== w[11:0] || smp_cnt !== 16'(exp_cnt)) begin
          bad++; $display("FAIL single_rand data=%h cnt=%0d want %h %0d", dat_q[lb], smp_cnt, w[11:0], exp_cnt);
        end
      end
    end
  endtask

  task automatic test_periodic();
    int lb, fb; bit ok, ok2;
    lb = len_q.size(); fb = fall_q.size();
    words.push_back(16'h0001); words.push_back(16'h0002); words.push_back(16'h0003);
    smp_rdy = 1'b1; cfg_period = 16'd200; cfg_en = 1'b1;
    wait_rec(lb + 3, ok);
    cfg_en = 1'b0;
    wait_idle(ok2);
    total++;
    if (!ok || !ok2) begin bad++; $display("FAIL periodic_timeout frames=%0d", len_q.size() - lb); return; end
    exp_cnt += 3;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (dat_q[lb+i] !== 12'(i + 1) || vat_q[lb+i] !== 1'b1) begin
        bad++; $display("FAIL periodic_data idx=%0d data=%h vld=%b want %h 1", i, dat_q[lb+i], vat_q[lb+i], 12'(i + 1));
      end
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (fall_q[fb+i+1] - fall_q[fb+i] != 200) begin
        bad++; $display("FAIL periodic_spacing idx=%0d got=%0d want 200", i, fall_q[fb+i+1] - fall_q[fb+i]);
      end
    end
    total++;
    if (overrun !== 1'b0 || smp_cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL periodic_status ovr=%b cnt=%0d want 0 %0d", overrun, smp_cnt, exp_cnt);
    end
  endtask

  task automatic test_drop();
    int plist[5]; int lb, fb, pe, sp; bit ok, ok2;
    plist[0] = 100; plist[1] = 0; plist[2] = FRAME;
    plist[3] = int'($urandom_range(1, FRAME - 1));
    plist[4] = int'($urandom_range(FRAME + 1, 300));
    smp_rdy = 1'b1;
    foreach (plist[k]) begin
      pe = (plist[k] == 0) ? 1 : plist[k];
      sp = pe * ((FRAME + pe - 1) / pe);
      lb = len_q.size(); fb = fall_q.size();
      cfg_period = 16'(plist[k]); cfg_en = 1'b1;
      wait_rec(lb + 3, ok);
      cfg_en = 1'b0;
      wait_idle(ok2);
      total++;
      if (!ok || !ok2) begin bad++; $display("FAIL drop_timeout period=%0d", plist[k]); continue; end
      exp_cnt += 3;
      total++;
      if (fall_q[fb+1] - fall_q[fb] != sp || fall_q[fb+2] - fall_q[fb+1] != sp) begin
        bad++; $display("FAIL drop_spacing period=%0d got=%0d,%0d want %0d", plist[k],
                        fall_q[fb+1] - fall_q[fb], fall_q[fb+2] - fall_q[fb+1], sp);
      end
      total++;
      if (len_q[lb] != FRAME_LOW || len_q[lb+1] != FRAME_LOW || len_q[lb+2] != FRAME_LOW || smp_cnt !== 16'(exp_cnt)) begin
        bad++; $display("FAIL drop_frame period=%0d low=%0d,%0d,%0d cnt=%0d want %0d cnt %0d", plist[k],
                        len_q[lb], len_q[lb+1], len_q[lb+2], smp_cnt, FRAME_LOW, exp_cnt);
      end
    end
  endtask

  task automatic test_overrun();
    bit ok, ok2; logic [15:0] w;
    smp_rdy = 1'b0;
    words.push_back(16'h0111); words.push_back(16'h0222);
    pulse_trig(); wait_idle(ok);
    total++;
    if (!ok || smp_vld !== 1'b1 || overrun !== 1'b0 || smp_data !== 12'h111) begin
      bad++; $display("FAIL ovr_first vld=%b ovr=%b data=%h want 1 0 111", smp_vld, overrun, smp_data);
    end
    pulse_trig(); wait_idle(ok);
    total++;
    if (!ok || smp_vld !== 1'b1 || overrun !== 1'b1 || smp_data !== 12'h222) begin
      bad++; $display("FAIL ovr_second vld=%b ovr=%b data=%h want 1 1 222", smp_vld, overrun, smp_data);
    end
    @(negedge clk_sys); ovr_clr = 1'b1; @(negedge clk_sys); ovr_clr = 1'b0;
    total++;
    if (overrun !== 1'b0 || smp_vld !== 1'b1) begin
      bad++; $display("FAIL ovr_clear ovr=%b vld=%b want 0 1", overrun, smp_vld);
    end
    w = 16'($urandom); words.push_back(w);
    pulse_trig(); wait_fall(ok);
    repeat (FRAME_LOW - 1) @(negedge clk_sys);
    total++;
    if (!ok || ad_cs_n !== 1'b0 || smp_vld !== 1'b1 || smp_data !== 12'h222) begin
      bad++; $display("FAIL ovr_precap cs_n=%b vld=%b data=%h want 0 1 222", ad_cs_n, smp_vld, smp_data);
    end
    smp_rdy = 1'b1; @(negedge clk_sys); smp_rdy = 1'b0;
    total++;
    if (ad_cs_n !== 1'b1 || smp_vld !== 1'b1 || overrun !== 1'b0 || smp_data !== w[11:0]) begin
      bad++; $display("FAIL ovr_same_cycle_hs cs_n=%b vld=%b ovr=%b data=%h want 1 1 0 %h",
                      ad_cs_n, smp_vld, overrun, smp_data, w[11:0]);
    end
    wait_idle(ok2);
    w = 16'($urandom); words.push_back(w);
    pulse_trig(); wait_fall(ok);
    repeat (FRAME_LOW - 1) @(negedge clk_sys);
    ovr_clr = 1'b1; @(negedge clk_sys); ovr_clr = 1'b0;
    total++;
    if (!ok || overrun !== 1'b1 || smp_vld !== 1'b1 || smp_data !== w[11:0]) begin
      bad++; $display("FAIL ovr_set_beats_clr ovr=%b vld=%b data=%h want 1 1 %h", overrun, smp_vld, smp_data, w[11:0]);
    end
    @(negedge clk_sys); ovr_clr = 1'b1; @(negedge clk_sys); ovr_clr = 1'b0;
    total++;
    if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_final_clear ovr=%b want 0", overrun); end
    wait_idle(ok2);
    exp_cnt += 4;
  endtask

  task automatic test_reset_mid();
    int lb; bit ok, ok2; logic [15:0] w;
    words.push_back(16'($urandom));
    pulse_trig();
    repeat (60) @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    total++;
    if ({ad_cs_n, ad_sclk, smp_vld, busy, overrun} !== 5'b11000 || smp_cnt !== 16'd0 || smp_data !== 12'd0) begin
      bad++; $display("FAIL midreset cs_n=%b sclk=%b vld=%b busy=%b ovr=%b cnt=%h data=%h want 1 1 0 0 0 0000 000",
                      ad_cs_n, ad_sclk, smp_vld, busy, overrun, smp_cnt, smp_data);
    end
    @(negedge clk_sys); @(negedge clk_sys);
    rst_n = 1'b1;
    exp_cnt = 0;
    @(negedge clk_sys); @(negedge clk_sys);
    lb = len_q.size();
    w = 16'($urandom); words.push_back(w);
    smp_rdy = 1'b1;
    pulse_trig(); wait_rec(lb + 1, ok); wait_idle(ok2);
    total++;
    if (!ok || !ok2) begin bad++; $display("FAIL midreset_timeout"); return; end
    exp_cnt++;
    total++;
    if (len_q[lb] != FRAME_LOW || rise_q[lb] != 16 || dat_q[lb] !== w[11:0] || smp_cnt !== 16'(exp_cnt)) begin
      bad++; $display("FAIL midreset_frame low=%0d rises=%0d data=%h cnt=%0d want %0d 16 %h %0d",
                      len_q[lb], rise_q[lb], dat_q[lb], smp_cnt, FRAME_LOW, w[11:0], exp_cnt);
    end
  endtask

  task automatic test_wrap();
    int lb, fb; bit ok, ok2; logic [15:0] w;
    @(negedge clk_sys);
    force dut.smp_cnt_q = 16'hFFFF;
    @(negedge clk_sys);
    release dut.smp_cnt_q;
    lb = len_q.size(); fb = fall_q.size();
    w = 16'($urandom); words.push_back(w);
    smp_rdy = 1'b1;
    pulse_trig();
    repeat (30) @(negedge clk_sys);
    pulse_trig();
    wait_rec(lb + 1, ok); wait_idle(ok2);
    repeat (150) @(negedge clk_sys);
    total++;
    if (!ok || !ok2) begin bad++; $display("FAIL wrap_timeout"); return; end
    total++;
    if (smp_cnt !== 16'h0000 || fall_q.size() - fb != 1 || dat_q[lb] !== w[11:0]) begin
      bad++; $display("FAIL wrap cnt=%h frames=%0d data=%h want 0000 1 %h", smp_cnt, fall_q.size() - fb, dat_q[lb], w[11:0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_periodic();
    test_drop();
    test_overrun();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
